gold_dot_acc: RTL and testbench
===============================

Name: gold_dot_acc

Overview:
- Upstream feeder for the Goldilocks fast 256-bit reducer (p = 0xFFFFFFFF00000001).
- Accepts a stream of 64x64-bit operand pairs over a valid/ready handshake. Multiplies each pair iteratively, one 32x32 partial product per cycle, into a 256-bit accumulator.
- On the last term of a dot product, emits the accumulator as eight 32-bit limbs a..h, ready to wire directly to the reducer inputs.
- Used for NTT/MSM inner products before modular reduction.

Parameters:
- CNT_W, 16, width of the per-dot-product term counter (saturating).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair this cycle
- in_x  in  64  multiplicand
- in_y  in  64  multiplier
- in_last  in  1  pair is the final term of the current dot product
- out_valid  out  1  one-cycle pulse: limbs updated with a new result
- limb_a  out  32  result bits [255:224]
- limb_b  out  32  result bits [223:192]
- limb_c  out  32  result bits [191:160]
- limb_d  out  32  result bits [159:128]
- limb_e  out  32  result bits [127:96]
- limb_f  out  32  result bits [95:64]
- limb_g  out  32  result bits [63:32]
- limb_h  out  32  result bits [31:0]
- result_terms  out  CNT_W  number of terms in the emitted result, saturating
- busy  out  1  high in the MUL state

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; accumulator, term counter, operand latches and step counter all 0.
  - All limbs 0, result_terms=0, out_valid=0, busy=0.
  - in_ready=1 after release.
- States: IDLE, MUL.
- IDLE:
  - in_ready=1, busy=0.
  - Accept on an edge with in_valid=1: latch in_x, in_y and in_last; step=0; go to MUL.
  - Term counter increments on accept and saturates at all-ones.
- MUL:
  - in_ready=0, busy=1; in_valid is ignored.
  - Step 0: acc += x[31:0]*y[31:0].
  - Step 1: acc += x[31:0]*y[63:32] << 32.
  - Step 2: acc += x[63:32]*y[31:0] << 32.
  - Step 3: acc += x[63:32]*y[63:32] << 64.
  - Arithmetic is unsigned, 256-bit, modulo 2^256. Wrap requires more than 2^128 terms and is not flagged.
- At the step-3 edge:
  - If latched last=0: acc holds the new sum; go to IDLE.
  - If latched last=1:
    - Limbs load (acc + step-3 partial product); a is the MSB limb, h the LSB limb.
    - result_terms loads the counter value.
    - out_valid=1 for exactly that cycle.
    - acc and term counter clear to 0; go to IDLE.
- Timing:
  - Accept at edge k; steps at edges k+1..k+4.
  - out_valid is high in the cycle following edge k+4.
  - Earliest next accept is edge k+5, giving 5 cycles per term.
- Outputs hold between results:
  - Limbs and result_terms hold their value until the next result.
  - The downstream reducer samples them freely; there is no output back-pressure.
- in_last on the first term yields the single product x*y.
- Reset mid-MUL: the partial sum and term count are discarded; no out_valid is generated.
- Operands may change on the input bus during MUL without effect, because they are latched at accept.

Test Plan:
- Single term, x=y=0xFFFFFFFFFFFFFFFF, last=1 -> out_valid the cycle after edge k+4:
  - a..d=0, e=0xFFFFFFFF, f=0xFFFFFFFE, g=0, h=0x00000001.
  - result_terms=1.
- Three terms (2,3), (5,7), (0x100000000, 0x100000000), last on third:
  - f=0x00000001, h=0x00000029, all other limbs 0.
  - result_terms=3.
- Two terms, each x=y=0xFFFFFFFFFFFFFFFF, last on second:
  - d=0x00000001, e=0xFFFFFFFF, f=0xFFFFFFFC, g=0, h=0x00000002.
  - Checks carry across limbs.
- Hold in_valid=1 continuously with in_last=0 for 12 cycles, then send one last pair:
  - in_ready low during every MUL.
  - Exactly one accept per 5 cycles.
  - result_terms equals accepted count plus 1.
  - Limbs hold between pulses.
- Assert rst_n=0 during step 2 of a term:
  - All outputs immediately 0; no out_valid.
  - After release, the single term (3,4) with last -> h=0x0000000C, others 0, result_terms=1.

Source files
------------

// File: rtl/gold_dot_acc_if.sv
// Operand/result bundle between the dot-product feeder and its neighbours.
// master = upstream source that also watches the result limbs; slave = gold_dot_acc.
interface gold_dot_acc_if #(
    parameter int CNT_W = 16
);
    // A pair transfers on a rising edge where in_valid && in_ready; the source
    // holds in_x/in_y/in_last stable while in_valid is high and not yet accepted.
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_x;
    logic [63:0]      in_y;
    logic             in_last;
    logic             out_valid;
    logic [31:0]      limb_a;
    logic [31:0]      limb_b;
    logic [31:0]      limb_c;
    logic [31:0]      limb_d;
    logic [31:0]      limb_e;
    logic [31:0]      limb_f;
    logic [31:0]      limb_g;
    logic [31:0]      limb_h;
    logic [CNT_W-1:0] result_terms;
    logic             busy;

    modport master (
        output in_valid, in_x, in_y, in_last,
        input  in_ready, out_valid, limb_a, limb_b, limb_c, limb_d,
               limb_e, limb_f, limb_g, limb_h, result_terms, busy
    );

    modport slave (
        input  in_valid, in_x, in_y, in_last,
        output in_ready, out_valid, limb_a, limb_b, limb_c, limb_d,
               limb_e, limb_f, limb_g, limb_h, result_terms, busy
    );
endinterface

// File: rtl/gold_dot_acc.sv
// 64x64 multiply-accumulate feeder for the Goldilocks 256-bit reducer: one
// 32x32 partial product per cycle into a 256-bit accumulator, result as 8 limbs.
module gold_dot_acc #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    gold_dot_acc_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [255:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      x_q, x_d;
    logic [63:0]      y_q, y_d;
    logic             last_q, last_d;
    logic [1:0]       step_q, step_d;
    logic [255:0]     res_q, res_d;
    logic [CNT_W-1:0] terms_q, terms_d;
    logic             out_valid_q, out_valid_d;

    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [6:0]       shamt;
    logic [63:0]      prod;
    logic [255:0]     pp;
    logic [255:0]     acc_sum;

    // Step order walks the schoolbook cross terms: lo*lo, lo*hi, hi*lo, hi*hi.
    always_comb begin
        op_a  = x_q[31:0];
        op_b  = y_q[31:0];
        shamt = 7'd0;
        case (step_q)
            2'd0: begin op_a = x_q[31:0];  op_b = y_q[31:0];  shamt = 7'd0;  end
            2'd1: begin op_a = x_q[31:0];  op_b = y_q[63:32]; shamt = 7'd32; end
            2'd2: begin op_a = x_q[63:32]; op_b = y_q[31:0];  shamt = 7'd32; end
            default: begin op_a = x_q[63:32]; op_b = y_q[63:32]; shamt = 7'd64; end
        endcase
        prod    = {32'd0, op_a} * {32'd0, op_b};
        pp      = {192'd0, prod} << shamt;
        acc_sum = acc_q + pp;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        last_d      = last_q;
        step_d      = step_q;
        res_d       = res_q;
        terms_d     = terms_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.in_x;
                    y_d     = bus.in_y;
                    last_d  = bus.in_last;
                    step_d  = 2'd0;
                    cnt_d   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                    state_d = MUL;
                end
            end
            default: begin
                acc_d  = acc_sum;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = IDLE;
                    if (last_q) begin
                        res_d       = acc_sum;
                        terms_d     = cnt_q;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            last_q      <= 1'b0;
            step_q      <= 2'd0;
            res_q       <= '0;
            terms_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            last_q      <= last_d;
            step_q      <= step_d;
            res_q       <= res_d;
            terms_q     <= terms_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign bus.busy         = (state_q == MUL);
    assign bus.out_valid    = out_valid_q;
    assign bus.result_terms = terms_q;
    assign bus.limb_a       = res_q[255:224];
    assign bus.limb_b       = res_q[223:192];
    assign bus.limb_c       = res_q[191:160];
    assign bus.limb_d       = res_q[159:128];
    assign bus.limb_e       = res_q[127:96];
    assign bus.limb_f       = res_q[95:64];
    assign bus.limb_g       = res_q[63:32];
    assign bus.limb_h       = res_q[31:0];
endmodule

// File: tb/tb_gold_dot_acc.sv
// Directed bench for gold_dot_acc: single/multi-term products, limb carries,
// continuous-valid throughput, and reset in the middle of a multiply.
module tb_gold_dot_acc;
    localparam int CNT_W = 16;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    gold_dot_acc_if #(.CNT_W(CNT_W)) bus ();

    gold_dot_acc #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [255:0]     exp_res   = '0;
    logic [CNT_W-1:0] exp_terms = '0;
    logic [255:0]     res;

    assign res = {bus.limb_a, bus.limb_b, bus.limb_c, bus.limb_d,
                  bus.limb_e, bus.limb_f, bus.limb_g, bus.limb_h};

    // Waits (bounded) for in_ready at a falling edge, presents the pair across
    // the next rising edge, then scrambles the bus to prove operands were latched.
    task automatic send_term(input logic [63:0] x, input logic [63:0] y, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%0b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_x     = {$urandom, $urandom};
        bus.in_y     = {$urandom, $urandom};
        bus.in_last  = ~last;
    endtask

    // Called right after send_term: checks the four MUL cycles, then the
    // cycle after edge k+4. For a last term the new result is checked and
    // becomes the held value; otherwise the old result must still be held.
    task automatic expect_term(input logic last, input string name,
                               input logic [255:0] new_res, input logic [CNT_W-1:0] new_terms);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_mul_cycle%0d: busy=%0b in_ready=%0b out_valid=%0b required 1 0 0",
                         name, i, bus.busy, bus.in_ready, bus.out_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== last || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: out_valid=%0b busy=%0b required %0b 0",
                     name, bus.out_valid, bus.busy, last);
        end
        if (last) begin
            exp_res   = new_res;
            exp_terms = new_terms;
        end
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s_limbs: got %h required %h", name, res, exp_res);
        end
        checks++;
        if (bus.result_terms !== exp_terms) begin
            errors++;
            $display("FAIL %s_terms: got %0d required %0d", name, bus.result_terms, exp_terms);
        end
        if (last) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || res !== exp_res || bus.result_terms !== exp_terms) begin
                errors++;
                $display("FAIL %s_hold: out_valid=%0b limbs=%h terms=%0d required 0 %h %0d",
                         name, bus.out_valid, res, bus.result_terms, exp_res, exp_terms);
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_last  = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (res !== 256'd0 || bus.result_terms !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: limbs=%h terms=%0d out_valid=%0b busy=%0b required all 0",
                     res, bus.result_terms, bus.out_valid, bus.busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%0b busy=%0b required 1 0", bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_single();
        send_term(ONES, ONES, 1'b1);
        expect_term(1'b1, "single",
                    256'h0000_0000_0000_0000_0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001,
                    16'd1);
    endtask

    task automatic test_three_terms();
        send_term(64'd2, 64'd3, 1'b0);
        expect_term(1'b0, "three_t1", '0, '0);
        send_term(64'd5, 64'd7, 1'b0);
        expect_term(1'b0, "three_t2", '0, '0);
        send_term(64'h1_0000_0000, 64'h1_0000_0000, 1'b1);
        expect_term(1'b1, "three_t3",
                    256'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0001_0000_0000_0000_0029,
                    16'd3);
    endtask

    task automatic test_two_terms_carry();
        send_term(ONES, ONES, 1'b0);
        expect_term(1'b0, "carry_t1", '0, '0);
        send_term(ONES, ONES, 1'b1);
        expect_term(1'b1, "carry_t2",
                    256'h0000_0000_0000_0000_0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFC_0000_0000_0000_0002,
                    16'd2);
    endtask

    // in_valid held high for 12 cycles: accepts land at cycles 0, 5 and 10.
    task automatic test_back_to_back();
        int acc_cnt;
        int last_acc;
        acc_cnt  = 0;
        last_acc = -1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x     = 64'd1;
        bus.in_y     = 64'd1;
        bus.in_last  = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            checks++;
            if (bus.in_ready !== ~bus.busy || bus.out_valid !== 1'b0 || res !== exp_res) begin
                errors++;
                $display("FAIL b2b_cycle%0d: in_ready=%0b busy=%0b out_valid=%0b limbs=%h required ready=!busy 0 %h",
                         cyc, bus.in_ready, bus.busy, bus.out_valid, res, exp_res);
            end
            if (bus.in_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 5) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles required 5", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                acc_cnt++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++;
        if (acc_cnt != 3) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d required 3", acc_cnt);
        end
        send_term(64'd1, 64'd1, 1'b1);
        expect_term(1'b1, "b2b_last", 256'd4, 16'd4);
    endtask

    task automatic test_reset_mid_mul();
        send_term(64'd7, 64'd7, 1'b0);
        expect_term(1'b0, "rst_t1", '0, '0);
        send_term(64'd9, 64'd9, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (res !== 256'd0 || bus.result_terms !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: limbs=%h terms=%0d out_valid=%0b busy=%0b required all 0",
                     res, bus.result_terms, bus.out_valid, bus.busy);
        end
        exp_res   = '0;
        exp_terms = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || res !== 256'd0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_quiet%0d: out_valid=%0b limbs=%h in_ready=%0b required 0 0 1",
                         i, bus.out_valid, res, bus.in_ready);
            end
        end
        send_term(64'd3, 64'd4, 1'b1);
        expect_term(1'b1, "rst_after", 256'h0C, 16'd1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_three_terms();
        test_two_terms_carry();
        test_back_to_back();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
